// File: rtl/retroaction_dac_writer.sv
// Streams controller samples to the trap-actuator DAC over write-only SPI (CPOL=0, CPHA=0).
// Optional feature macro: DAC_SLEW_LIMIT_EN (per-frame code slew limit toward the pending target).
module retroaction_dac_writer #(
  parameter int              input_bit_size = 16,
  parameter int              input_frac_size = 15,
  parameter int              dac_bit_size   = 16,
  parameter int              cmd_bit_size   = 8,
  parameter logic [7:0]      dac_cmd        = 8'h30,
  parameter int              sclk_half      = 4,
  parameter int              cs_high_cycles = 4,
  parameter int              max_step       = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [input_bit_size-1:0] sample,
  input  logic                      sample_valid,
  input  logic                      dac_enable,
  output logic                      dac_sclk,
  output logic                      dac_mosi,
  output logic                      dac_cs_n,
  output logic                      busy,
  output logic                      frame_done,
  output logic [dac_bit_size-1:0]   last_code,
  output logic [15:0]               dropped_count
);

  localparam int FRAME_W = cmd_bit_size + dac_bit_size;
  localparam int SHIFT_L = (dac_bit_size - 1) - input_frac_size;
  localparam int SHL     = (SHIFT_L > 0) ? SHIFT_L : 0;
  localparam int SHR     = (SHIFT_L < 0) ? -SHIFT_L : 0;
  localparam int EXT_W   = ((input_bit_size + SHL > dac_bit_size) ? input_bit_size + SHL : dac_bit_size) + 1;
  localparam int CNT_MAX = (sclk_half > cs_high_cycles) ? sclk_half : cs_high_cycles;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BIT_W   = $clog2(FRAME_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_CSHIGH} state_t;

  state_t                    state_r, state_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic [BIT_W-1:0]          bit_cnt_r, bit_cnt_s;
  logic [FRAME_W-1:0]        shreg_r, shreg_s;
  logic [dac_bit_size-1:0]   code_r, code_s;
  logic [dac_bit_size-1:0]   pend_code_r, pend_code_s;
  logic [dac_bit_size-1:0]   last_code_r, last_code_s;
  logic [dac_bit_size-1:0]   load_code_s;
  logic [15:0]               dropped_r, dropped_s;
  logic                      pending_r, pending_s;
  logic                      sclk_r, sclk_s, mosi_r, mosi_s, cs_n_r, cs_n_s;
  logic                      frame_done_r, frame_done_s, busy_r;
  logic                      load_s, accept_s;

  // Align to dac_bit_size-1 fractional bits, saturate to signed DAC range, then flip MSB to offset-binary.
  function automatic logic [dac_bit_size-1:0] to_offset_binary(input logic [input_bit_size-1:0] s);
    logic signed [EXT_W-1:0] v;
    logic [dac_bit_size-1:0] code;
    v = {{(EXT_W-input_bit_size){s[input_bit_size-1]}}, s};
    v = (v <<< SHL) >>> SHR;
    if ((&v[EXT_W-1:dac_bit_size-1]) || (~|v[EXT_W-1:dac_bit_size-1])) begin
      code = v[dac_bit_size-1:0];
    end else if (v[EXT_W-1]) begin
      code = {1'b1, {(dac_bit_size-1){1'b0}}};
    end else begin
      code = {1'b0, {(dac_bit_size-1){1'b1}}};
    end
    return {~code[dac_bit_size-1], code[dac_bit_size-2:0]};
  endfunction

`ifdef DAC_SLEW_LIMIT_EN
  // Unsigned clamp of target to base +/- max_step; one extra bit keeps the sums from wrapping.
  function automatic logic [dac_bit_size-1:0] slew_clamp(input logic [dac_bit_size-1:0] target,
                                                         input logic [dac_bit_size-1:0] base);
    logic [dac_bit_size:0] t, b, step, r;
    t    = {1'b0, target};
    b    = {1'b0, base};
    step = (dac_bit_size+1)'(max_step);
    if (t > b + step) begin
      r = b + step;
    end else if (b > t + step) begin
      r = b - step;
    end else begin
      r = t;
    end
    return r[dac_bit_size-1:0];
  endfunction
`endif

  // Next-state, SPI shifting, sample buffer and drop counter.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bit_cnt_s    = bit_cnt_r;
    shreg_s      = shreg_r;
    code_s       = code_r;
    sclk_s       = sclk_r;
    mosi_s       = mosi_r;
    cs_n_s       = cs_n_r;
    frame_done_s = 1'b0;
    last_code_s  = last_code_r;
    pending_s    = pending_r;
    pend_code_s  = pend_code_r;
    dropped_s    = dropped_r;
`ifdef DAC_SLEW_LIMIT_EN
    load_code_s  = slew_clamp(pend_code_r, last_code_r);
`else
    load_code_s  = pend_code_r;
`endif
    load_s       = (state_r == S_IDLE) && pending_r;
    accept_s     = sample_valid && dac_enable;

    case (state_r)
      S_IDLE: begin
        if (pending_r) begin
          shreg_s   = {dac_cmd[cmd_bit_size-1:0], load_code_s};
          code_s    = load_code_s;
          // A clamped step keeps the original target pending for the next frame.
          pending_s = (load_code_s != pend_code_r);
          cs_n_s    = 1'b0;
          mosi_s    = dac_cmd[cmd_bit_size-1];
          cnt_s     = {CNT_W{1'b0}};
          bit_cnt_s = {BIT_W{1'b0}};
          state_s   = S_SETUP;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_r == CNT_W'(sclk_half - 1)) begin
          cnt_s   = {CNT_W{1'b0}};
          sclk_s  = 1'b1;
          state_s = S_SHIFT;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_r != CNT_W'(sclk_half - 1)) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = {CNT_W{1'b0}};
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else if (bit_cnt_r == BIT_W'(FRAME_W - 1)) begin
            sclk_s       = 1'b0;
            cs_n_s       = 1'b1;
            frame_done_s = 1'b1;
            last_code_s  = code_r;
            state_s      = S_CSHIGH;
          end else begin
            sclk_s    = 1'b0;
            shreg_s   = {shreg_r[FRAME_W-2:0], 1'b0};
            mosi_s    = shreg_r[FRAME_W-2];
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
          end
        end
      end
      S_CSHIGH: begin
        if (cnt_r == CNT_W'(cs_high_cycles - 1)) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
      end
    endcase

    if (accept_s) begin
      pend_code_s = to_offset_binary(sample);
      pending_s   = 1'b1;
      if (pending_r && !load_s && (dropped_r != 16'hFFFF)) begin
        dropped_s = dropped_r + 16'd1;
      end else begin
        dropped_s = dropped_r;
      end
    end else begin
      pend_code_s = pend_code_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      shreg_r      <= {FRAME_W{1'b0}};
      code_r       <= {1'b1, {(dac_bit_size-1){1'b0}}};
      pend_code_r  <= {dac_bit_size{1'b0}};
      last_code_r  <= {1'b1, {(dac_bit_size-1){1'b0}}};
      dropped_r    <= 16'd0;
      pending_r    <= 1'b0;
      sclk_r       <= 1'b0;
      mosi_r       <= 1'b0;
      cs_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      shreg_r      <= shreg_s;
      code_r       <= code_s;
      pend_code_r  <= pend_code_s;
      last_code_r  <= last_code_s;
      dropped_r    <= dropped_s;
      pending_r    <= pending_s;
      sclk_r       <= sclk_s;
      mosi_r       <= mosi_s;
      cs_n_r       <= cs_n_s;
      frame_done_r <= frame_done_s;
      busy_r       <= (state_s != S_IDLE);
    end
  end

  assign dac_sclk      = sclk_r;
  assign dac_mosi      = mosi_r;
  assign dac_cs_n      = cs_n_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign last_code     = last_code_r;
  assign dropped_count = dropped_r;

endmodule

// File: tb/tb_retroaction_dac_writer.sv
// Self-checking bench for retroaction_dac_writer: an SPI monitor decodes frames and
// scenario tasks compare them with codes computed from the fixed-point conversion rules.
module tb_retroaction_dac_writer;

  logic        clk = 1'b0;
  logic        reset, sample_valid, dac_enable;
  logic [15:0] sample;
  logic        dac_sclk, dac_mosi, dac_cs_n, busy, frame_done;
  logic [15:0] last_code, dropped_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  retroaction_dac_writer dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .dac_enable(dac_enable), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .dac_cs_n(dac_cs_n),
    .busy(busy), .frame_done(frame_done), .last_code(last_code), .dropped_count(dropped_count)
  );

  typedef struct {
    logic [23:0] bits;
    int          nbits;
    int          low;
    int          gap;
  } frame_t;

  frame_t      frames_q[$];
  frame_t      mon_f;
  int          fd_cnt = 0, fd_bad = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [23:0] cur_bits = 24'h0;
  int          cur_n = 0, cur_low = 0, cur_gap = 0, high_cnt = 0;

  // SPI monitor: bits captured on rising sclk while cs_n is low; cs_n low/high durations in clk cycles.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (dac_cs_n === 1'b1 && prev_cs === 1'b0 && reset === 1'b1 && frame_done !== 1'b1) fd_bad++;
    if (dac_cs_n === 1'b0) begin
      if (prev_cs === 1'b1) begin
        cur_bits = 24'h0; cur_n = 0; cur_low = 0; cur_gap = high_cnt;
      end
      cur_low++;
      if (dac_sclk === 1'b1 && prev_sclk === 1'b0) begin
        cur_bits = {cur_bits[22:0], dac_mosi};
        cur_n++;
      end
    end else begin
      if (prev_cs === 1'b0) begin
        mon_f.bits = cur_bits; mon_f.nbits = cur_n; mon_f.low = cur_low; mon_f.gap = cur_gap;
        frames_q.push_back(mon_f);
        high_cnt = 0;
      end
      high_cnt++;
    end
    prev_cs   = dac_cs_n;
    prev_sclk = dac_sclk;
  end

  // Reference conversion: value in units of 2^-15, rescaled to 15 DAC fractional bits,
  // clipped to the signed 16-bit range and offset by mid-scale.
  function automatic logic [15:0] model_code(input logic [15:0] s);
    int v;
    v = $signed(s);
    v = v * (1 << (15 - 15));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v + 32768);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    sample = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int k = 0;
    while (frames_q.size() < n && k < 2000) begin tick(); k++; end
    ok = (frames_q.size() >= n);
  endtask

  task automatic wait_cs_low(output bit ok);
    int k = 0;
    while (dac_cs_n !== 1'b0 && k < 20) begin tick(); k++; end
    ok = (dac_cs_n === 1'b0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 500) begin tick(); k++; end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_valid = 1'b0; dac_enable = 1'b1; sample = 16'h0;
    repeat (3) tick();
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", dac_cs_n); end
    checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", dac_sclk); end
    checks++; if (dac_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", dac_mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (last_code !== 16'h8000) begin errors++; $display("FAIL reset_last_code: got %h expected 8000", last_code); end
    checks++; if (dropped_count !== 16'h0) begin errors++; $display("FAIL reset_dropped: got %h expected 0", dropped_count); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok; frame_t f; int fd0;
    frames_q.delete(); fd0 = fd_cnt;
    send(16'h0000);
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL latency_cs_early: got %b expected 1", dac_cs_n); end
    tick();
    checks++; if (dac_cs_n !== 1'b0) begin errors++; $display("FAIL latency_cs_low: got %b expected 0", dac_cs_n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy: got %b expected 1", busy); end
    wait_frames(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d frames expected 1", frames_q.size()); end
    else begin
      f = frames_q.pop_front();
      checks++; if (f.bits !== 24'h308000) begin errors++; $display("FAIL single_frame: got %h expected 308000", f.bits); end
      checks++; if (f.nbits !== 24) begin errors++; $display("FAIL single_nbits: got %0d expected 24", f.nbits); end
      checks++; if (f.low !== 2 * 4 * 24) begin errors++; $display("FAIL single_cs_low_len: got %0d expected %0d", f.low, 2 * 4 * 24); end
    end
    wait_idle();
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL single_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    checks++; if (last_code !== 16'h8000) begin errors++; $display("FAIL single_last_code: got %h expected 8000", last_code); end
  endtask

  task automatic test_extremes();
    logic [15:0] ins [2];
    logic [23:0] exp_f [2];
    bit ok; frame_t f;
    ins[0] = 16'h7FFF; exp_f[0] = 24'h30FFFF;
    ins[1] = 16'h8000; exp_f[1] = 24'h300000;
    for (int i = 0; i < 2; i++) begin
      frames_q.delete();
      send(ins[i]);
      wait_frames(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL extreme_timeout[%0d]: got 0 frames expected 1", i); end
      else begin
        f = frames_q.pop_front();
        checks++; if (f.bits !== exp_f[i]) begin errors++; $display("FAIL extreme_frame[%0d]: got %h expected %h", i, f.bits, exp_f[i]); end
      end
      wait_idle();
      checks++; if (last_code !== exp_f[i][15:0]) begin errors++; $display("FAIL extreme_last_code[%0d]: got %h expected %h", i, last_code, exp_f[i][15:0]); end
    end
  endtask

  task automatic test_overwrite();
    bit ok; frame_t f0, f1; logic [15:0] r0, d0;
    frames_q.delete(); d0 = dropped_count; r0 = 16'($urandom);
    send(r0);
    wait_cs_low(ok);
    checks++; if (!ok) begin errors++; $display("FAIL overwrite_start: got cs_n %b expected 0", dac_cs_n); end
    repeat (5) tick();
    send(16'h1000); tick(); send(16'h2000); send(16'h3000);
    checks++; if (dropped_count !== 16'(d0 + 16'd2)) begin errors++; $display("FAIL overwrite_dropped: got %0d expected %0d", dropped_count, d0 + 16'd2); end
    wait_frames(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overwrite_timeout: got %0d frames expected 2", frames_q.size()); end
    else begin
      f0 = frames_q.pop_front(); f1 = frames_q.pop_front();
      checks++; if (f0.bits !== {8'h30, model_code(r0)}) begin errors++; $display("FAIL overwrite_first: got %h expected %h", f0.bits, {8'h30, model_code(r0)}); end
      checks++; if (f1.bits !== 24'h30B000) begin errors++; $display("FAIL overwrite_latest: got %h expected 30B000", f1.bits); end
      checks++; if (f1.gap < 4) begin errors++; $display("FAIL back_to_back_gap: got %0d expected >=4", f1.gap); end
    end
    wait_idle();
    checks++; if (frames_q.size() !== 0) begin errors++; $display("FAIL overwrite_extra: got %0d frames expected 0", frames_q.size()); end
  endtask

  task automatic test_random_bursts();
    bit ok; frame_t f; logic [15:0] r0, last; int k, nexp; logic [15:0] exp_drop;
    reset = 1'b0; repeat (2) tick(); reset = 1'b1; tick();
    exp_drop = 16'd0;
    for (int it = 0; it < 12; it++) begin
      frames_q.delete();
      r0 = 16'($urandom); k = $urandom_range(0, 3); last = r0;
      send(r0);
      wait_cs_low(ok);
      repeat ($urandom_range(1, 20)) tick();
      for (int j = 0; j < k; j++) begin
        last = 16'($urandom);
        send(last);
        repeat ($urandom_range(0, 3)) tick();
      end
      if (k > 1) exp_drop = exp_drop + 16'(k - 1);
      checks++; if (dropped_count !== exp_drop) begin errors++; $display("FAIL rand_dropped[%0d]: got %0d expected %0d", it, dropped_count, exp_drop); end
      nexp = (k > 0) ? 2 : 1;
      wait_frames(nexp, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout[%0d]: got %0d frames expected %0d", it, frames_q.size(), nexp); end
      else begin
        f = frames_q.pop_front();
        checks++; if (f.bits !== {8'h30, model_code(r0)}) begin errors++; $display("FAIL rand_first[%0d]: got %h expected %h", it, f.bits, {8'h30, model_code(r0)}); end
        if (k > 0) begin
          f = frames_q.pop_front();
          checks++; if (f.bits !== {8'h30, model_code(last)}) begin errors++; $display("FAIL rand_latest[%0d]: got %h expected %h", it, f.bits, {8'h30, model_code(last)}); end
        end
      end
      wait_idle();
      checks++; if (last_code !== model_code(last)) begin errors++; $display("FAIL rand_last_code[%0d]: got %h expected %h", it, last_code, model_code(last)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int fd0;
    send(16'($urandom));
    wait_cs_low(ok);
    repeat (60) tick();
    send(16'($urandom)); send(16'($urandom));
    fd0 = fd_cnt;
    reset = 1'b0;
    tick();
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL midreset_cs_n: got %b expected 1", dac_cs_n); end
    checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL midreset_sclk: got %b expected 0", dac_sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (dropped_count !== 16'h0) begin errors++; $display("FAIL midreset_dropped: got %0d expected 0", dropped_count); end
    checks++; if (last_code !== 16'h8000) begin errors++; $display("FAIL midreset_last_code: got %h expected 8000", last_code); end
    checks++; if (fd_cnt !== fd0) begin errors++; $display("FAIL midreset_frame_done: got %0d pulses expected 0", fd_cnt - fd0); end
    reset = 1'b1;
    tick();
    frames_q.delete();
    repeat (250) tick();
    checks++; if (frames_q.size() !== 0) begin errors++; $display("FAIL midreset_pending: got %0d frames expected 0", frames_q.size()); end
  endtask

  task automatic test_disable();
    bit ok; frame_t f; logic [15:0] d0, v;
    frames_q.delete(); d0 = dropped_count;
    dac_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin send(16'($urandom)); tick(); end
    repeat (30) tick();
    checks++; if (frames_q.size() !== 0) begin errors++; $display("FAIL disable_frames: got %0d expected 0", frames_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b expected 0", busy); end
    dac_enable = 1'b1;
    v = 16'($urandom);
    send(v);
    wait_cs_low(ok);
    dac_enable = 1'b0;
    repeat (10) tick();
    send(16'($urandom));
    wait_frames(1, ok);
    repeat (250) tick();
    checks++; if (frames_q.size() !== 1) begin errors++; $display("FAIL disable_inflight_count: got %0d expected 1", frames_q.size()); end
    else begin
      f = frames_q.pop_front();
      checks++; if (f.bits !== {8'h30, model_code(v)}) begin errors++; $display("FAIL disable_inflight_frame: got %h expected %h", f.bits, {8'h30, model_code(v)}); end
    end
    checks++; if (dropped_count !== d0) begin errors++; $display("FAIL disable_dropped: got %0d expected %0d", dropped_count, d0); end
    dac_enable = 1'b1;
  endtask

`ifdef DAC_SLEW_LIMIT_EN
  task automatic test_slew();
    bit ok; frame_t f; logic [23:0] exp_f;
    frames_q.delete();
    send(16'h0300);
    wait_frames(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slew_timeout: got %0d frames expected 3", frames_q.size()); end
    repeat (300) tick();
    checks++; if (frames_q.size() !== 3) begin errors++; $display("FAIL slew_count: got %0d expected 3", frames_q.size()); end
    for (int i = 0; i < 3 && frames_q.size() > 0; i++) begin
      f = frames_q.pop_front();
      exp_f = {8'h30, 16'(32768 + 256 * (i + 1))};
      checks++; if (f.bits !== exp_f) begin errors++; $display("FAIL slew_frame[%0d]: got %h expected %h", i, f.bits, exp_f); end
    end
    checks++; if (last_code !== 16'h8300) begin errors++; $display("FAIL slew_last_code: got %h expected 8300", last_code); end
    checks++; if (dropped_count !== 16'h0) begin errors++; $display("FAIL slew_dropped: got %0d expected 0", dropped_count); end
  endtask
`endif

  initial begin
    reset = 1'b0; sample_valid = 1'b0; dac_enable = 1'b1; sample = 16'h0;
    test_reset();
`ifdef DAC_SLEW_LIMIT_EN
    test_slew();
`else
    test_single();
    test_extremes();
    test_overwrite();
    test_random_bursts();
    test_reset_mid();
    test_disable();
`endif
    checks++; if (fd_bad !== 0) begin errors++; $display("FAIL frame_done_align: got %0d misaligned frame ends expected 0", fd_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
